apb_bridge: RTL and testbench

APB master bridge that generates a self-sequenced stream of APB transfers toward a single peripheral whenever the `transfer` request is high. An internal address/data sequencer produces each transfer. The block runs the standard IDLE/SETUP/ACCESS handshake and honours peripheral wait states via `pready`. It sits between a simple request source and one APB slave.

---
 rtl/apb_bridge.sv | 114 +++++++++++
 tb/tb_apb_bridge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge.sv
// rtl/apb_bridge.sv - APB master bridge driving a self-sequenced transfer stream
// Parameters: WIDTH - address/data width (even, >= 8), default 16.
// Inputs : pclk, preset_n (synchronous, active-high), transfer, pready, prdata[WIDTH].
// Outputs: pselect, penable, pwrite, pwdata[WIDTH], paddr[WIDTH]; all registered.
// Option : APB_BRIDGE_READBACK_EN - each address is written, then read back; the
//          read data plus one seeds the next write. Undefined: every transfer is a write.
module apb_bridge #(
  parameter int WIDTH = 16
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic             transfer,
  input  logic             pready,
  input  logic [WIDTH-1:0] prdata,
  output logic             pselect,
  output logic             penable,
  output logic             pwrite,
  output logic [WIDTH-1:0] pwdata,
  output logic [WIDTH-1:0] paddr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] addr_q, data_q;
  logic             op_q;        // 0 = next transfer is a write, 1 = read

  // Sequencer contents after the transfer in ACCESS completes. A back-to-back
  // SETUP loads its outputs from these so it sees the post-completion values.
  logic [WIDTH-1:0] addr_nx, data_nx;
  logic             op_nx;

`ifdef APB_BRIDGE_READBACK_EN
  always_comb begin
    addr_nx = addr_q;
    data_nx = data_q;
    op_nx   = op_q;
    if (op_q) begin
      addr_nx = addr_q + ONE;
      data_nx = prdata + ONE;
      op_nx   = 1'b0;
    end else begin
      op_nx   = 1'b1;
    end
  end
`else
  // Read data has no role when every transfer is a write.
  logic unused_prdata;
  assign unused_prdata = ^prdata;

  always_comb begin
    addr_nx = addr_q + ONE;
    data_nx = data_q + ONE;
    op_nx   = 1'b0;
  end
`endif

  always_ff @(posedge pclk) begin
    if (preset_n) begin
      state   <= IDLE;
      pselect <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      pwdata  <= '0;
      paddr   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (transfer) begin
            state   <= SETUP;
            pselect <= 1'b1;
            penable <= 1'b0;
            paddr   <= addr_q;
            pwdata  <= data_q;
            pwrite  <= ~op_q;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          // Without pready everything holds: a wait state.
          if (pready) begin
            addr_q  <= addr_nx;
            data_q  <= data_nx;
            op_q    <= op_nx;
            penable <= 1'b0;
            if (transfer) begin
              state  <= SETUP;
              paddr  <= addr_nx;
              pwdata <= data_nx;
              pwrite <= ~op_nx;
            end else begin
              state   <= IDLE;
              pselect <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          pselect <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge.sv
// tb/tb_apb_bridge.sv - scoreboard bench for apb_bridge with a transaction-level model
module tb_apb_bridge;

  localparam int W = 16;

  logic         pclk = 1'b0;
  logic         preset_n, transfer, pready;
  logic [W-1:0] prdata;
  logic         pselect, penable, pwrite;
  logic [W-1:0] pwdata, paddr;

  always #5 pclk = ~pclk;

  apb_bridge #(.WIDTH(W)) dut (
    .pclk(pclk), .preset_n(preset_n), .transfer(transfer), .pready(pready),
    .prdata(prdata), .pselect(pselect), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .paddr(paddr)
  );

  // Narrow instance streaming freely to exercise address/data wrap-around.
  logic       rst8 = 1'b1;
  logic       pselect8, penable8, pwrite8;
  logic [7:0] pwdata8, paddr8;

  apb_bridge #(.WIDTH(8)) dut8 (
    .pclk(pclk), .preset_n(rst8), .transfer(1'b1), .pready(1'b1),
    .prdata(8'h00), .pselect(pselect8), .penable(penable8), .pwrite(pwrite8),
    .pwdata(pwdata8), .paddr(paddr8)
  );

`ifdef APB_BRIDGE_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {logic wr; logic [W-1:0] addr; logic [W-1:0] data;} xfer_t;
  typedef struct packed {logic sel; logic en; logic zero;} phase_t;

  localparam phase_t PH_IDLE  = '{sel: 1'b0, en: 1'b0, zero: 1'b0};
  localparam phase_t PH_SETUP = '{sel: 1'b1, en: 1'b0, zero: 1'b0};
  localparam phase_t PH_ACC   = '{sel: 1'b1, en: 1'b1, zero: 1'b0};
  localparam phase_t PH_RST   = '{sel: 1'b0, en: 1'b0, zero: 1'b1};

  xfer_t  exp_q[$];
  phase_t ph_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: what the next transfer should be and how
  // the stream advances once a transfer completes.
  logic [W-1:0] m_addr, m_data;
  logic         m_rd;

  task automatic model_reset();
    m_addr = '0;
    m_data = '0;
    m_rd   = 1'b0;
  endtask

  function automatic xfer_t model_next();
    return '{wr: ~m_rd, addr: m_addr, data: m_data};
  endfunction

  task automatic model_complete(input logic [W-1:0] rd);
    if (RB) begin
      if (!m_rd) m_rd = 1'b1;
      else begin
        m_addr = m_addr + 1;
        m_data = rd + 1;
        m_rd   = 1'b0;
      end
    end else begin
      m_addr = m_addr + 1;
      m_data = m_data + 1;
    end
  endtask

  // One clock of stimulus; ph is the bus phase required after the next edge.
  task automatic cyc(input logic t, input logic r, input logic rst,
                     input phase_t ph, input logic [W-1:0] pd);
    @(negedge pclk);
    transfer = t;
    pready   = r;
    preset_n = rst;
    prdata   = pd;
    ph_q.push_back(ph);
  endtask

  bit           fix_rd = 1'b0;
  logic [W-1:0] fixed_rd_val = 16'h1234;

  task automatic burst(input int n, input int wmin, input int wmax, input bit rst_mid);
    bit           last, aborted;
    int           w;
    logic         ts;
    logic [W-1:0] rd;
    xfer_t        x;
    aborted = 1'b0;
    cyc(1'b1, 1'($urandom), 1'b0, PH_SETUP, W'($urandom));
    for (int i = 0; i < n && !aborted; i++) begin
      last = (i == n - 1);
      w    = $urandom_range(wmax, wmin);
      if (rst_mid && last && w == 0) w = 1;
      x    = model_next();
      // Dropping transfer during the final SETUP must not abort it.
      ts   = last ? 1'($urandom) : 1'b1;
      cyc(ts, 1'($urandom), 1'b0, PH_ACC, W'($urandom));
      for (int j = 0; j < w && !aborted; j++) begin
        if (rst_mid && last) begin
          cyc(1'b1, 1'b0, 1'b1, PH_RST, W'($urandom));
          model_reset();
          aborted = 1'b1;
        end else begin
          cyc(last ? 1'($urandom) : 1'b1, 1'b0, 1'b0, PH_ACC, W'($urandom));
        end
      end
      if (!aborted) begin
        rd = fix_rd ? fixed_rd_val : W'($urandom);
        cyc(~last, 1'b1, 1'b0, last ? PH_IDLE : PH_SETUP, rd);
        exp_q.push_back(x);
        model_complete(rd);
      end
    end
    repeat ($urandom_range(3, 1)) cyc(1'b0, 1'($urandom), 1'b0, PH_IDLE, W'($urandom));
  endtask

  // Monitor: checks bus phase every cycle, hold/stability rules, and each
  // completed transfer against the scoreboard.
  logic         p_sel, p_en, p_wr;
  logic [W-1:0] p_addr, p_data;
  bit           p_valid = 1'b0;

  initial begin
    phase_t ph;
    xfer_t  x;
    forever begin
      @(posedge pclk);
      #1;
      if (p_valid && p_sel && p_en && pready && !preset_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_completion", W'(1), W'(0));
        end else begin
          x = exp_q.pop_front();
          check("xfer_pwrite", W'(p_wr), W'(x.wr));
          check("xfer_paddr", p_addr, x.addr);
          check("xfer_pwdata", p_data, x.data);
        end
      end
      if (ph_q.size() > 0) begin
        ph = ph_q.pop_front();
        check("pselect", W'(pselect), W'(ph.sel));
        check("penable", W'(penable), W'(ph.en));
        if (ph.zero) begin
          check("rst_paddr", paddr, '0);
          check("rst_pwdata", pwdata, '0);
          check("rst_pwrite", W'(pwrite), '0);
        end else if (p_valid && (ph.en || !ph.sel)) begin
          check("hold_paddr", paddr, p_addr);
          check("hold_pwdata", pwdata, p_data);
          check("hold_pwrite", W'(pwrite), W'(p_wr));
        end
        p_sel   = pselect;
        p_en    = penable;
        p_wr    = pwrite;
        p_addr  = paddr;
        p_data  = pwdata;
        p_valid = 1'b1;
      end
    end
  end

  // Wrap monitor for the narrow instance: k-th SETUP carries address k
  // (k/2 when writes and reads alternate), modulo 256.
  int n8 = 0;
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge pclk);
      #1;
      if (!rst8 && pselect8 && !penable8) begin
        e = RB ? 8'(n8 / 2) : 8'(n8);
        check("wrap_paddr", W'(paddr8), W'(e));
        if (!RB) check("wrap_pwdata", W'(pwdata8), W'(e));
        n8++;
      end
    end
  end

  initial begin
    int lim, bound;
    preset_n = 1'b1;
    transfer = 1'b0;
    pready   = 1'b0;
    prdata   = '0;
    model_reset();
    repeat (2) @(negedge pclk);
    rst8 = 1'b0;
  end

  initial begin
    int lim, bound;
    model_reset();
    // Reset for two edges, the second with transfer high to show priority.
    cyc(1'b0, 1'b0, 1'b1, PH_RST, '0);
    cyc(1'b1, 1'b1, 1'b1, PH_RST, '0);
    repeat (3) cyc(1'b0, 1'($urandom), 1'b0, PH_IDLE, W'($urandom));
    fix_rd = 1'b1;
    burst(3, 0, 0, 1'b0);
    fix_rd = 1'b0;
    burst(5, 0, 0, 1'b0);
    burst(2, 3, 3, 1'b0);
    burst(3, 1, 3, 1'b1);
    burst(2, 0, 1, 1'b0);
    for (int b = 0; b < 30; b++)
      burst($urandom_range(6, 1), 0, 3, $urandom_range(9, 0) == 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, PH_IDLE, '0);
    @(posedge pclk);
    #2;
    check("pending_xfers", W'(exp_q.size()), '0);
    lim   = RB ? 600 : 300;
    bound = 0;
    while (n8 < lim && bound < 4000) begin
      @(posedge pclk);
      bound++;
    end
    check("wrap_progress", W'(n8 >= lim), W'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
